// File: rtl/env_sequencer_if.sv
// Register-file and mixer side signals of the envelope sequencer, bundled so the
// controller (master) and the sequencer (slave) share one connection.
interface env_sequencer_if #(
  parameter int NUM_VOICES = 3
);
  logic                       sample_tick_i;
  logic [NUM_VOICES-1:0]      gate_i;
  logic [NUM_VOICES-1:0][7:0] ad_i;
  logic [NUM_VOICES-1:0][7:0] sr_i;
  logic [NUM_VOICES-1:0][7:0] env_level_o;
  logic                       busy_o;
  logic                       done_o;
  logic                       overrun_o;

  modport master (
    output sample_tick_i, gate_i, ad_i, sr_i,
    input  env_level_o, busy_o, done_o, overrun_o
  );

  modport slave (
    input  sample_tick_i, gate_i, ad_i, sr_i,
    output env_level_o, busy_o, done_o, overrun_o
  );
endinterface

// File: rtl/env_sequencer.sv
// Time-multiplexed ADSR envelope sequencer: each sample tick walks every voice
// through one shared update datapath (LOAD then UPDATE per voice).
module env_sequencer #(
  parameter int NUM_VOICES = 3
) (
  input logic            clk_i,
  input logic            rst_ni,
  env_sequencer_if.slave bus
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_UPDATE,
    S_DONE
  } seq_state_t;

  typedef enum logic [2:0] {
    E_OFF,
    E_ATTACK,
    E_DECAY,
    E_SUSTAIN,
    E_RELEASE
  } env_state_t;

  seq_state_t state_q, state_nx;
  logic [IDX_W-1:0] idx_q, idx_nx;
  logic load_en;
  logic vld_p0;
  logic overrun_q;

  env_state_t                 env_st_q [NUM_VOICES];
  logic [NUM_VOICES-1:0][7:0] level_q;
  logic [14:0]                presc_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0]      pgate_q;

  env_state_t  st_p0;
  logic [7:0]  level_p0;
  logic [14:0] presc_p0;
  logic        pgate_p0;
  logic        gate_p0;
  logic [7:0]  ad_p0;
  logic [7:0]  sr_p0;

  env_state_t  st_nx;
  logic [7:0]  level_nx;
  logic [14:0] presc_nx;
  logic [14:0] presc_step;
  logic [7:0]  target;
  logic [3:0]  rate;
  logic        expired;

  function automatic logic [7:0] sat_inc(input logic [7:0] l);
    return (l == 8'hFF) ? 8'hFF : l + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] l);
    return (l == 8'h00) ? 8'h00 : l - 8'd1;
  endfunction

  function automatic logic rate_expired(input logic [14:0] presc, input logic [3:0] r);
    logic [15:0] limit;
    limit = (16'd1 << r) - 16'd1;
    return {1'b0, presc} >= limit;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      vld_p0    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_nx;
      idx_q     <= idx_nx;
      vld_p0    <= load_en;
      overrun_q <= bus.sample_tick_i && (state_q != S_IDLE);
    end
  end

  always_comb begin
    state_nx = state_q;
    idx_nx   = idx_q;
    load_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.sample_tick_i) begin
          state_nx = S_LOAD;
          idx_nx   = '0;
        end
      end
      S_LOAD: begin
        load_en  = 1'b1;
        state_nx = S_UPDATE;
      end
      S_UPDATE: begin
        if (idx_q == LAST_IDX) begin
          state_nx = S_DONE;
        end else begin
          idx_nx   = idx_q + IDX_W'(1);
          state_nx = S_LOAD;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Stage p0: latch the selected voice's storage and register inputs
  always_ff @(posedge clk_i) begin
    if (load_en) begin
      st_p0    <= env_st_q[idx_q];
      level_p0 <= level_q[idx_q];
      presc_p0 <= presc_q[idx_q];
      pgate_p0 <= pgate_q[idx_q];
      gate_p0  <= bus.gate_i[idx_q];
      ad_p0    <= bus.ad_i[idx_q];
      sr_p0    <= bus.sr_i[idx_q];
    end
  end

  // Gate edges override the envelope step; otherwise advance by one tick
  always_comb begin
    st_nx    = st_p0;
    level_nx = level_p0;
    presc_nx = presc_p0;
    target   = {sr_p0[7:4], sr_p0[7:4]};
    case (st_p0)
      E_ATTACK:  rate = ad_p0[7:4];
      E_DECAY:   rate = ad_p0[3:0];
      E_RELEASE: rate = sr_p0[3:0];
      default:   rate = 4'd0;
    endcase
    expired    = rate_expired(presc_p0, rate);
    presc_step = expired ? 15'd0 : presc_p0 + 15'd1;

    if (gate_p0 && !pgate_p0) begin
      st_nx    = E_ATTACK;
      presc_nx = '0;
    end else if (!gate_p0 && pgate_p0) begin
      st_nx    = E_RELEASE;
      presc_nx = '0;
    end else begin
      case (st_p0)
        E_ATTACK: begin
          if (level_p0 == 8'hFF) begin
            st_nx    = E_DECAY;
            presc_nx = '0;
          end else begin
            presc_nx = presc_step;
            if (expired) begin
              level_nx = sat_inc(level_p0);
              if (level_nx == 8'hFF) st_nx = E_DECAY;
            end
          end
        end
        E_DECAY: begin
          if (level_p0 <= target) begin
            st_nx    = E_SUSTAIN;
            level_nx = target;
          end else begin
            presc_nx = presc_step;
            if (expired) level_nx = sat_dec(level_p0);
          end
        end
        E_SUSTAIN: level_nx = target;
        E_RELEASE: begin
          if (level_p0 == 8'h00) begin
            st_nx = E_OFF;
          end else begin
            presc_nx = presc_step;
            if (expired) begin
              level_nx = sat_dec(level_p0);
              if (level_nx == 8'h00) st_nx = E_OFF;
            end
          end
        end
        default: begin
          st_nx    = E_OFF;
          level_nx = 8'h00;
        end
      endcase
    end
  end

  // Write-back of the updated voice; reset discards any sweep in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        env_st_q[v] <= E_OFF;
        presc_q[v]  <= '0;
      end
      level_q <= '0;
      pgate_q <= '0;
    end else if (vld_p0) begin
      env_st_q[idx_q] <= st_nx;
      level_q[idx_q]  <= level_nx;
      presc_q[idx_q]  <= presc_nx;
      pgate_q[idx_q]  <= gate_p0;
    end
  end

  assign bus.env_level_o = level_q;
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.overrun_o   = overrun_q;
endmodule
